mont_domain_conv: RTL and testbench

- Digit-serial Montgomery domain converter for the NTT datapath.
- Forward (dir=0): maps a normal-form residue into Montgomery form, out = A·R mod M. Computed as MontMul(A, R2).
- Reverse (dir=1): maps a Montgomery-form residue back to normal form, out = A·R⁻¹ mod M. Computed as MontMul(A, 1).
- R = 2^W. Sits at the NTT input/output boundary. Processes one M_BITS digit per cycle behind a valid/ready handshake.

---
 rtl/mont_domain_conv.sv | 144 ++++++++++++++
 tb/tb_mont_domain_conv.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mont_domain_conv.sv
// mont_domain_conv
// Digit-serial Montgomery domain converter for the NTT boundary.
//   dir=0 : out = A*R   mod M, computed as MontMul(A, R2)
//   dir=1 : out = A*R^-1 mod M, computed as MontMul(A, 1)
// One M_BITS digit of A is consumed per cycle. A final conditional
// subtraction brings the result into [0, M).
`timescale 1ns/1ps
module mont_domain_conv #(
    parameter int W      = 32,
    parameter int M_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    input  logic              dir,
    input  logic [W-1:0]      M,
    input  logic [M_BITS-1:0] M_inv,
    input  logic [W-1:0]      R2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data
);

    localparam int N  = W / M_BITS;
    // Datapath width: S (< 2M) plus a_i*B needs W+M_BITS+1 bits, and adding
    // q*M needs one more carry bit, so nothing is ever truncated.
    localparam int DW = W + M_BITS + 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [W-1:0]      r_a;        // operand, shifted right one digit per RUN cycle
    logic [W-1:0]      r_b;        // captured multiplier (R2 or 1)
    logic [W-1:0]      r_m;        // captured modulus
    logic [M_BITS-1:0] r_minv;     // captured -M^-1 mod 2^M_BITS
    logic [W:0]        r_s;        // running accumulator, < 2M for valid operands
    logic [IW-1:0]     r_idx;      // digit index
    logic              r_in_ready;
    logic              r_out_valid;
    logic [W-1:0]      r_out_data;

    logic [M_BITS-1:0] w_digit;
    logic [DW-1:0]     w_t;
    logic [M_BITS-1:0] w_q;
    logic [DW-1:0]     w_u;
    logic [W:0]        w_s_next;
    logic              w_ge;
    logic [W-1:0]      w_fix;
    logic [W-1:0]      w_one;

    // One Montgomery digit step plus the final conditional subtraction.
    always_comb begin
        w_one    = {{(W-1){1'b0}}, 1'b1};
        w_digit  = r_a[M_BITS-1:0];
        w_t      = DW'(r_s) + (DW'(w_digit) * DW'(r_b));
        // q only needs the low digit of T times M_inv, modulo 2^M_BITS.
        w_q      = M_BITS'(w_t[M_BITS-1:0] * r_minv);
        w_u      = w_t + (DW'(w_q) * DW'(r_m));
        // Low digit of T+q*M is zero by construction; shift it out.
        w_s_next = (W+1)'(w_u >> M_BITS);
        w_ge     = (r_s >= {1'b0, r_m});
        if (w_ge) begin
            w_fix = W'(r_s - {1'b0, r_m});
        end else begin
            w_fix = W'(r_s);
        end
    end

    // Control FSM with registered handshake outputs and datapath state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_a         <= {W{1'b0}};
            r_b         <= {W{1'b0}};
            r_m         <= {W{1'b0}};
            r_minv      <= {M_BITS{1'b0}};
            r_s         <= {(W+1){1'b0}};
            r_idx       <= {IW{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= {W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_data;
                        r_b        <= dir ? w_one : R2;
                        r_m        <= M;
                        r_minv     <= M_inv;
                        r_s        <= {(W+1){1'b0}};
                        r_idx      <= {IW{1'b0}};
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_s   <= w_s_next;
                    r_a   <= r_a >> M_BITS;
                    r_idx <= r_idx + IW'(1);
                    if (r_idx == IW'(N - 1)) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FIX: begin
                    r_out_data  <= w_fix;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    // Result is held until the consumer takes it.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_mont_domain_conv.sv
// Directed bench for mont_domain_conv with M=3329, R=2^32.
`timescale 1ns/1ps
module tb_mont_domain_conv;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        dir;
    logic [31:0] M;
    logic [7:0]  M_inv;
    logic [31:0] R2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] MOD  = 32'd3329;
    localparam logic [31:0] RMOD = 32'd1353;

    mont_domain_conv #(.W(32), .M_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .dir       (dir),
        .M         (M),
        .M_inv     (M_inv),
        .R2        (R2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One complete conversion; optionally scrambles the inputs right after capture.
    task automatic run_conv(input logic d, input logic [31:0] a, input bit scramble,
                            output logic [31:0] res, output int lat, output bit rdy_seen);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_val("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dir      = d;
        in_data  = a;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (scramble) begin
            dir     = ~d;
            R2      = 32'd0;
            M_inv   = 8'd0;
            in_data = 32'd0;
        end
        lat      = 1;
        rdy_seen = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_val("out_valid_seen", {31'd0, out_valid}, 32'd1);
        res   = out_data;
        dir   = d;
        R2    = 32'd2988;
        M_inv = 8'd255;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] fwd;
        logic [31:0] a;
        logic [63:0] prod;
        int          lat;
        bit          rdy_seen;
        int          guard;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        dir       = 1'b0;
        M         = MOD;
        M_inv     = 8'd255;
        R2        = 32'd2988;
        out_ready = 1'b0;

        // Reset state
        #12;
        check_val("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_out_data",  out_data,           32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Forward of 1 gives R mod M with fixed latency; busy throughout.
        run_conv(1'b0, 32'd1, 1'b0, res, lat, rdy_seen);
        check_val("fwd_1", res, 32'd1353);
        check_val("latency", lat, 32'd6);
        check_val("busy_in_ready", {31'd0, rdy_seen}, 32'd0);

        run_conv(1'b1, 32'd1353, 1'b0, res, lat, rdy_seen);
        check_val("rev_1353", res, 32'd1);
        run_conv(1'b0, 32'd3328, 1'b0, res, lat, rdy_seen);
        check_val("fwd_m_minus_1", res, 32'd1976);
        run_conv(1'b0, 32'd0, 1'b0, res, lat, rdy_seen);
        check_val("fwd_0", res, 32'd0);
        run_conv(1'b1, 32'd0, 1'b0, res, lat, rdy_seen);
        check_val("rev_0", res, 32'd0);
        run_conv(1'b1, 32'd1976, 1'b0, res, lat, rdy_seen);
        check_val("rev_1976", res, 32'd3328);

        // Inputs changed after capture must not matter.
        run_conv(1'b0, 32'd7, 1'b1, res, lat, rdy_seen);
        check_val("scramble_fwd_7", res, 32'd2813);
        run_conv(1'b1, 32'd1353, 1'b1, res, lat, rdy_seen);
        check_val("scramble_rev_1353", res, 32'd1);

        // Back-pressure: result held, new requests ignored.
        @(negedge clk);
        in_valid = 1'b1;
        dir      = 1'b0;
        in_data  = 32'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            in_data  = 32'd123;
            @(negedge clk);
            check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check_val("bp_out_data",  out_data,           32'd107);
            check_val("bp_in_ready",  {31'd0, in_ready},  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_val("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check_val("bp_release_ready", {31'd0, in_ready},  32'd1);

        // Asynchronous reset in the middle of RUN.
        in_valid = 1'b1;
        dir      = 1'b0;
        in_data  = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_val("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check_val("mid_rst_no_output", {31'd0, out_valid}, 32'd0);
        run_conv(1'b0, 32'd2, 1'b0, res, lat, rdy_seen);
        check_val("post_rst_fwd_2", res, 32'd2706);

        // Round trip against an arithmetic reference model.
        for (int n = 0; n < 1000; n++) begin
            a    = 32'($urandom_range(3328, 0));
            prod = (64'(a) * 64'(RMOD)) % 64'(MOD);
            run_conv(1'b0, a, 1'b0, fwd, lat, rdy_seen);
            check_val("rt_fwd", fwd, prod[31:0]);
            run_conv(1'b1, fwd, 1'b0, res, lat, rdy_seen);
            check_val("rt_rev", res, a);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
